// File: rtl/baluga_isa_pkg.sv
// Shared ISA definitions for the baluga core: opcodes, instruction fields and
// decode-controller state encodings.
package baluga_isa_pkg;

    localparam int unsigned InstrWidth = 9;
    localparam int unsigned OpcodeMsb  = 8;
    localparam int unsigned OpcodeLsb  = 5;
    localparam int unsigned ImmMsb     = 4;
    localparam int unsigned ImmLsb     = 0;

    typedef logic [OpcodeMsb-OpcodeLsb:0] opcode_t;
    typedef logic [ImmMsb-ImmLsb:0]       imm5_t;

    localparam opcode_t OP_LD   = 4'hC;
    localparam opcode_t OP_JMP  = 4'hD;
    localparam opcode_t OP_BRZ  = 4'hE;
    localparam opcode_t OP_HALT = 4'hF;

    localparam logic [2:0] StInit  = 3'd0;
    localparam logic [2:0] StRun   = 3'd1;
    localparam logic [2:0] StStall = 3'd2;
    localparam logic [2:0] StFlush = 3'd3;
    localparam logic [2:0] StHalt  = 3'd4;

    function automatic opcode_t instr_opcode(input logic [InstrWidth-1:0] instr);
        return instr[OpcodeMsb:OpcodeLsb];
    endfunction

    function automatic imm5_t instr_imm(input logic [InstrWidth-1:0] instr);
        return instr[ImmMsb:ImmLsb];
    endfunction

endpackage

// File: rtl/stall_timer.sv
// 3-bit loadable down-counter that times the load-use stall window.
module stall_timer (
    input  logic       clock,
    input  logic       reset,
    input  logic       load_i,
    input  logic [2:0] load_val_i,
    input  logic       count_i,
    output logic       zero_o
);

    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (count_i && (cnt_q != 3'd0)) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 3'd0);

endmodule

// File: rtl/instr_decode_ctrl.sv
// Decode controller: turns the fetched instruction into registered branch, jump,
// stall and halt controls for the fetch unit, and counts retired instructions.
module instr_decode_ctrl
    import baluga_isa_pkg::*;
#(
    parameter int unsigned LOAD_STALL = 1,
    parameter int unsigned JMP_SHIFT  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            instruction_number,
    input  logic [InstrWidth-1:0] instr_word,
    input  logic                  zero_flag,
    input  logic [7:0]            branch_reg,
    output logic                  branch_ctrl,
    output logic                  jump_ctrl,
    output logic                  done_ctrl,
    output logic                  stall,
    output logic                  init_ctrl,
    output logic [7:0]            jump_val,
    output logic [7:0]            branch_val,
    output logic [15:0]           retired_count
);

    // The decode cycle supplies the first stall cycle, so the timer covers the rest.
    localparam logic [2:0] StallLoad = (LOAD_STALL > 1) ? 3'(LOAD_STALL - 2) : 3'd0;

    logic [2:0]  state_q, state_d;
    logic        init_q, init_d;
    logic        branch_q, branch_d;
    logic        jump_q, jump_d;
    logic        done_q, done_d;
    logic        stall_q, stall_d;
    logic [7:0]  jump_val_q, jump_val_d;
    logic [7:0]  branch_val_q, branch_val_d;
    logic [15:0] retired_q, retired_d;

    logic        retire;
    logic        tmr_load, tmr_count, tmr_zero;
    opcode_t     opcode;
    imm5_t       imm;
    logic [7:0]  jump_target;

    // The PC is part of the fetch interface but decode does not depend on it.
    logic unused_pc;
    assign unused_pc = ^instruction_number;

    assign opcode      = instr_opcode(instr_word);
    assign imm         = instr_imm(instr_word);
    assign jump_target = 8'(imm) << JMP_SHIFT;

    stall_timer u_stall_timer (
        .clock      (clock),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (StallLoad),
        .count_i    (tmr_count),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        init_d       = 1'b0;
        branch_d     = 1'b0;
        jump_d       = 1'b0;
        done_d       = 1'b0;
        stall_d      = 1'b0;
        jump_val_d   = jump_val_q;
        branch_val_d = branch_val_q;
        retire       = 1'b0;
        tmr_load     = 1'b0;
        tmr_count    = 1'b0;

        case (state_q)
            StInit: begin
                init_d  = 1'b1;
                state_d = StRun;
            end
            StRun: begin
                case (opcode)
                    OP_BRZ: begin
                        retire = 1'b1;
                        if (zero_flag) begin
                            branch_d     = 1'b1;
                            branch_val_d = branch_reg;
                            state_d      = StFlush;
                        end
                    end
                    OP_JMP: begin
                        retire     = 1'b1;
                        jump_d     = 1'b1;
                        jump_val_d = jump_target;
                        state_d    = StFlush;
                    end
                    OP_LD: begin
                        stall_d = 1'b1;
                        if (LOAD_STALL < 2) begin
                            retire = 1'b1;
                        end else begin
                            tmr_load = 1'b1;
                            state_d  = StStall;
                        end
                    end
                    OP_HALT: begin
                        retire  = 1'b1;
                        done_d  = 1'b1;
                        state_d = StHalt;
                    end
                    default: begin
                        retire = 1'b1;
                    end
                endcase
            end
            StStall: begin
                stall_d   = 1'b1;
                tmr_count = 1'b1;
                if (tmr_zero) begin
                    retire  = 1'b1;
                    state_d = StRun;
                end
            end
            StFlush: begin
                state_d = StRun;
            end
            StHalt: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = StInit;
            end
        endcase

        retired_d = retired_q + {15'd0, retire};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StInit;
            init_q       <= 1'b0;
            branch_q     <= 1'b0;
            jump_q       <= 1'b0;
            done_q       <= 1'b0;
            stall_q      <= 1'b0;
            jump_val_q   <= 8'h00;
            branch_val_q <= 8'h00;
            retired_q    <= 16'h0000;
        end else begin
            state_q      <= state_d;
            init_q       <= init_d;
            branch_q     <= branch_d;
            jump_q       <= jump_d;
            done_q       <= done_d;
            stall_q      <= stall_d;
            jump_val_q   <= jump_val_d;
            branch_val_q <= branch_val_d;
            retired_q    <= retired_d;
        end
    end

    assign init_ctrl     = init_q;
    assign branch_ctrl   = branch_q;
    assign jump_ctrl     = jump_q;
    assign done_ctrl     = done_q;
    assign stall         = stall_q;
    assign jump_val      = jump_val_q;
    assign branch_val    = branch_val_q;
    assign retired_count = retired_q;

endmodule

// File: doc/instr_decode_ctrl.md
INSTR_DECODE_CTRL -- requirements
Module: instr_decode_ctrl

Interface
REQ-001 Parameter LOAD_STALL, default 1, meaning extra stall cycles per LD instruction (legal range 1..7).
REQ-002 Parameter JMP_SHIFT, default 3, meaning left shift applied to the 5-bit jump immediate.
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 instruction_number  input  8  current PC value from the fetch unit.
REQ-006 instr_word  input  9  instruction at instruction_number; opcode = [8:5], imm5 = [4:0].
REQ-007 zero_flag  input  1  ALU zero result for BRZ evaluation.
REQ-008 branch_reg  input  8  current contents of the $branch register.
REQ-009 branch_ctrl, jump_ctrl, done_ctrl, stall, init_ctrl  output  1 each  registered fetch-unit controls.
REQ-010 jump_val, branch_val  output  8 each  registered fetch-unit targets.
REQ-011 retired_count  output  16  count of instructions that completed decode.

Function
REQ-012 All outputs SHALL be registered on posedge clock, so they are stable before the fetch unit's negedge PC update.
REQ-013 FSM states SHALL be INIT, RUN, STALL, FLUSH, HALT.
REQ-014 INIT: init_ctrl=1 for exactly one cycle, all other controls 0; next state RUN.
REQ-015 RUN decodes instr_word each cycle; at most one of branch_ctrl/jump_ctrl/done_ctrl/stall SHALL be 1 in any cycle.
REQ-016 Opcode 4'hE BRZ: if zero_flag=1 then branch_ctrl=1 for one cycle, branch_val=branch_reg, next state FLUSH; otherwise no control and stay in RUN.
REQ-017 Opcode 4'hD JMP: jump_ctrl=1 for one cycle, jump_val={imm5,3'b0} truncated to 8 bits per JMP_SHIFT; next state FLUSH.
REQ-018 Opcode 4'hC LD: stall=1 for LOAD_STALL consecutive cycles using a 3-bit down-counter in state STALL, then return to RUN; the LD instruction retires once, on its final stall cycle.
REQ-019 Opcode 4'hF HALT: done_ctrl=1 and held; next state HALT, which is absorbing until reset; all other controls 0.
REQ-020 All other opcodes: no control asserted; the instruction retires.
REQ-021 FLUSH lasts one cycle: instr_word is ignored (wrong-path), no control asserted, no retirement; next state RUN.
REQ-022 A taken BRZ, a JMP, and a HALT retire in the cycle their control is asserted.
REQ-023 branch_val and jump_val SHALL hold their last value when their strobe is 0.
REQ-024 retired_count SHALL increment by 1 per retirement and wrap from 16'hFFFF to 0.
REQ-025 branch_val arithmetic is the fetch unit's concern; this block passes branch_reg unmodified (two's-complement offset).
REQ-026 During STALL, instr_word and zero_flag changes SHALL be ignored.

Reset
REQ-027 reset=1 at a posedge SHALL force state INIT, the stall counter to 0, retired_count to 0, all 1-bit controls to 0, and jump_val and branch_val to 8'h00.
REQ-028 reset asserted mid-STALL or in HALT SHALL abort immediately; the first cycle after reset deasserts SHALL show init_ctrl=1.
REQ-029 reset has priority over every decode event in the same cycle.

Structure
REQ-030 Opcode constants (OP_BRZ, OP_JMP, OP_LD, OP_HALT), FSM state encodings, and instruction field positions SHALL live in the shared package baluga_isa_pkg.
REQ-031 The stall down-counter SHALL be a sub-module stall_timer (load, count, zero-flag output); all other logic stays in instr_decode_ctrl.

Verification
REQ-032 Release reset -> init_ctrl=1 for exactly one cycle, then RUN with all controls 0 and retired_count=0.
REQ-033 JMP with imm5=5'd4 -> jump_ctrl=1 for one cycle with jump_val=8'h20; the next instruction (ALU op) is flushed; retired_count increases by 1, not 2.
REQ-034 BRZ with branch_reg=8'hFC: zero_flag=1 -> branch_ctrl=1, branch_val=8'hFC, followed by one FLUSH cycle; zero_flag=0 -> no control, retires normally.
REQ-035 LD with LOAD_STALL=3 -> stall=1 for exactly 3 cycles while instr_word toggles; retired_count +1 at the end of the stall.
REQ-036 HALT -> done_ctrl=1 held for 10+ cycles; then reset -> done_ctrl=0 and init_ctrl=1 on the next cycle.
REQ-037 Preload 65535 retirements and retire one ALU op -> retired_count=16'h0000; assert reset during the 2nd of 3 stall cycles -> stall=0 on the next cycle.
